// File: rtl/rx_frame_sif.sv
// rx_frame_sif: collects switch read responses per TX transaction into frames buffered in a small FIFO
module rx_frame_sif #(
    parameter int NUM_SW_INST = 5,
    parameter int R_WIDTH     = 8,
    parameter int FRAME_WIDTH = 32,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT     = 15
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SW_INST-1:0]         sel_en,
    input  logic [7:0]                     addr,
    input  logic                           wr_rd_s,
    input  logic [7:0]                     op_id,
    input  logic [NUM_SW_INST*R_WIDTH-1:0] rd_data,
    input  logic [NUM_SW_INST-1:0]         rd_valid,
    output logic [FRAME_WIDTH-1:0]         frame_out,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic                           busy,
    output logic                           err_timeout,
    output logic                           collision
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT_RESP, PUSH} state_t;
    state_t               state_q, state_d;
    logic [7:0]           op_q, op_d, addr_q, addr_d;
    logic                 wr_q, wr_d, flag_q, flag_d, coll_q, coll_d;
    logic [2:0]           idx_q, idx_d, sel_idx;
    logic [R_WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]        tcnt_q, tcnt_d;
    logic                 one_hot, push, pop;
    logic [FRAME_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [PW:0]          fcnt_q;

    // binary index of the selected switch (meaningful only when one-hot)
    always_comb begin
        sel_idx = '0;
        for (int i = 0; i < NUM_SW_INST; i++)
            if (sel_en[i]) sel_idx = 3'(i);
    end

    assign one_hot     = (sel_en != '0) && ((sel_en & (sel_en - 1'b1)) == '0);
    assign pop         = frame_valid && frame_ready;
    assign frame_valid = fcnt_q != '0;
    assign frame_out   = mem_q[rd_ptr_q];
    assign busy        = state_q != IDLE;
    assign collision   = coll_q;

    // next-state logic: capture transaction, wait for the selected response or time out, then push
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wr_d        = wr_q;
        idx_d       = idx_q;
        data_d      = data_q;
        flag_d      = flag_q;
        tcnt_d      = tcnt_q;
        coll_d      = coll_q || (busy && sel_en != '0);
        err_timeout = 1'b0;
        push        = 1'b0;
        case (state_q)
            IDLE: begin
                if (one_hot) begin
                    op_d    = op_id;
                    addr_d  = addr;
                    wr_d    = wr_rd_s;
                    idx_d   = sel_idx;
                    data_d  = '0;
                    flag_d  = 1'b0;
                    tcnt_d  = '0;
                    state_d = wr_rd_s ? PUSH : WAIT_RESP;
                end else if (sel_en != '0) begin
                    coll_d = 1'b1;
                end
            end
            WAIT_RESP: begin
                if (rd_valid[idx_q]) begin
                    data_d  = rd_data[int'(idx_q)*R_WIDTH +: R_WIDTH];
                    state_d = PUSH;
                end else if (tcnt_q == CW'(TIMEOUT - 1)) begin
                    flag_d      = 1'b1;
                    err_timeout = 1'b1;
                    state_d     = PUSH;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            PUSH: begin
                push    = (fcnt_q != (PW+1)'(FIFO_DEPTH)) || pop;
                state_d = push ? IDLE : PUSH;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and captured-field registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            flag_q  <= 1'b0;
            tcnt_q  <= '0;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            tcnt_q  <= tcnt_d;
            coll_q  <= coll_d;
        end
    end

    // response FIFO; pointers wrap naturally since depth is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {op_q, addr_q, data_q, idx_q, wr_q, flag_q, 3'b000};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            fcnt_q <= fcnt_q + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_rx_frame_sif.sv
// tb_rx_frame_sif: directed checks of rx_frame_sif framing, latency, timeout, backpressure and reset
module tb_rx_frame_sif;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  sel_en = '0;
    logic [7:0]  addr = '0;
    logic        wr_rd_s = 1'b0;
    logic [7:0]  op_id = '0;
    logic [39:0] rd_data = '0;
    logic [4:0]  rd_valid = '0;
    logic [31:0] frame_out;
    logic        frame_valid, frame_ready = 1'b0, busy, err_timeout, collision;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] exp_q [5];

    rx_frame_sif dut (
        .clk(clk), .rst_n(rst_n), .sel_en(sel_en), .addr(addr), .wr_rd_s(wr_rd_s),
        .op_id(op_id), .rd_data(rd_data), .rd_valid(rd_valid), .frame_out(frame_out),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .busy(busy),
        .err_timeout(err_timeout), .collision(collision)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] sel, input logic [7:0] a, input logic [7:0] op, input logic wr);
        sel_en = sel; addr = a; op_id = op; wr_rd_s = wr;
        step();
        sel_en = '0;
    endtask

    task automatic respond(input int sw, input logic [7:0] d);
        rd_data = '0;
        rd_data[sw*8 +: 8] = d;
        rd_valid = 5'(1 << sw);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        #3 rst_n = 1'b1;
        step();
    endtask

    initial begin
        #12;
        chk("rst_frame_out", frame_out, 32'h0);
        chk("rst_valid", 32'(frame_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err_timeout), 32'd0);
        chk("rst_coll", 32'(collision), 32'd0);
        rst_n = 1'b1;
        step();

        issue(5'b00100, 8'h3C, 8'h11, 1'b0);
        chk("rd_busy_c1", 32'(busy), 32'd1);
        step(); step();
        respond(2, 8'hA5);
        step();
        rd_valid = '0;
        chk("rd_valid_c4", 32'(frame_valid), 32'd0);
        chk("rd_busy_c4", 32'(busy), 32'd1);
        step();
        chk("rd_valid_c5", 32'(frame_valid), 32'd1);
        chk("rd_frame", frame_out, 32'h113CA540);
        frame_ready = 1'b1; step(); frame_ready = 1'b0;
        chk("rd_popped", 32'(frame_valid), 32'd0);

        issue(5'b00001, 8'h07, 8'h22, 1'b1);
        chk("wr_valid_c1", 32'(frame_valid), 32'd0);
        step();
        chk("wr_valid_c2", 32'(frame_valid), 32'd1);
        chk("wr_frame", frame_out, 32'h22070010);
        chk("wr_busy_c2", 32'(busy), 32'd0);
        frame_ready = 1'b1; step(); frame_ready = 1'b0;

        issue(5'b10000, 8'h44, 8'h33, 1'b0);
        for (int c = 1; c < 14; c++) step();
        chk("to_err_c14", 32'(err_timeout), 32'd0);
        step();
        chk("to_err_c15", 32'(err_timeout), 32'd1);
        step();
        chk("to_err_c16", 32'(err_timeout), 32'd0);
        chk("to_valid_c16", 32'(frame_valid), 32'd0);
        step();
        chk("to_valid_c17", 32'(frame_valid), 32'd1);
        chk("to_frame", frame_out, 32'h33440088);
        frame_ready = 1'b1; step(); frame_ready = 1'b0;

        issue(5'b00110, 8'h01, 8'h02, 1'b1);
        chk("mh_coll", 32'(collision), 32'd1);
        chk("mh_busy", 32'(busy), 32'd0);
        step();
        chk("mh_noframe", 32'(frame_valid), 32'd0);
        do_reset();
        chk("mh_coll_cleared", 32'(collision), 32'd0);

        issue(5'b01000, 8'h66, 8'h55, 1'b0);
        respond(1, 8'hEE);
        step();
        rd_valid = '0;
        chk("ign_busy", 32'(busy), 32'd1);
        chk("ign_valid", 32'(frame_valid), 32'd0);
        for (int c = 2; c < 15; c++) step();
        respond(3, 8'h77);
        #1;
        chk("tie_err", 32'(err_timeout), 32'd0);
        step();
        rd_valid = '0;
        chk("tie_valid_c16", 32'(frame_valid), 32'd0);
        step();
        chk("tie_valid_c17", 32'(frame_valid), 32'd1);
        chk("tie_frame", frame_out, 32'h55667760);
        frame_ready = 1'b1; step(); frame_ready = 1'b0;

        for (int i = 0; i < 5; i++) begin
            exp_q[i] = {8'(8'hA0 + i), 8'(i), 8'h00, 3'(i), 1'b1, 4'h0};
            issue(5'(1 << i), 8'(i), 8'(8'hA0 + i), 1'b1);
            step(); step();
        end
        chk("bp_busy", 32'(busy), 32'd1);
        chk("bp_valid", 32'(frame_valid), 32'd1);
        chk("bp_coll_before", 32'(collision), 32'd0);
        issue(5'b00001, 8'hFF, 8'hFF, 1'b1);
        chk("bp_coll_after", 32'(collision), 32'd1);
        frame_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_drain%0d", k), frame_out, exp_q[k]);
            step();
        end
        frame_ready = 1'b0;
        chk("bp_empty", 32'(frame_valid), 32'd0);
        chk("bp_idle", 32'(busy), 32'd0);

        do_reset();
        issue(5'b00001, 8'h01, 8'h01, 1'b1);
        step(); step();
        issue(5'b00010, 8'h02, 8'h02, 1'b1);
        step(); step();
        issue(5'b00100, 8'h03, 8'h03, 1'b0);
        sel_en = 5'b00001;
        step();
        sel_en = '0;
        chk("mr_pre_coll", 32'(collision), 32'd1);
        chk("mr_pre_valid", 32'(frame_valid), 32'd1);
        chk("mr_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 32'(frame_valid), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        chk("mr_coll", 32'(collision), 32'd0);
        chk("mr_frame", frame_out, 32'h0);
        #2 rst_n = 1'b1;
        step();
        issue(5'b00010, 8'h10, 8'h99, 1'b0);
        respond(1, 8'h5A);
        step();
        rd_valid = '0;
        step();
        chk("mr_after_valid", 32'(frame_valid), 32'd1);
        chk("mr_after_frame", frame_out, 32'h99105A20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/rx_frame_sif.md
Name: rx_frame_sif

Overview:
Return-path companion to the TX frame serial interface. It watches each transaction the TX side issues to the switch instances (sel_en/addr/wr_rd_s/op_id), collects the selected switch's read response, and packs it into a response frame. Frames are buffered in a small FIFO and handed to the frame receiver via a valid/ready handshake. Missing responses are covered by a timeout.

Parameters:
NUM_SW_INST, 5, number of switch instances; sel_en/rd_valid width.
R_WIDTH, 8, read data width per switch.
FRAME_WIDTH, 32, response frame width; must equal R_WIDTH+24.
FIFO_DEPTH, 4, response FIFO entries (power of 2, >=2).
TIMEOUT, 15, max WAIT_RESP cycles before timeout (>=1).

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sel_en  input  NUM_SW_INST  one-hot switch select from TX side, 1 cycle per transaction
addr  input  8  register address of the transaction
wr_rd_s  input  1  1=write, 0=read
op_id  input  8  transaction tag
rd_data  input  NUM_SW_INST*R_WIDTH  concatenated read data; switch i at [i*R_WIDTH +: R_WIDTH]
rd_valid  input  NUM_SW_INST  per-switch read-data-valid
frame_out  output  FRAME_WIDTH  FIFO head response frame
frame_valid  output  1  FIFO not empty
frame_ready  input  1  consumer accepts frame_out
busy  output  1  FSM not IDLE
err_timeout  output  1  1-cycle pulse on response timeout
collision  output  1  sticky: transaction dropped (see below); cleared only by reset

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, FIFO empty, counter=0, captured fields=0. Outputs: frame_out=0, frame_valid=0, busy=0, err_timeout=0, collision=0.
- Frame format: [FRAME_WIDTH-1 -: 8]=op_id, next 8=addr, next R_WIDTH=data, [7:5]=switch index (binary), [4]=wr_rd_s, [3]=timeout flag, [2:0]=0.
- FSM states: IDLE, WAIT_RESP, PUSH.
- IDLE: if sel_en is one-hot, capture op_id, addr, wr_rd_s and the index. Read goes to WAIT_RESP with counter=0. Write goes to PUSH with data=0 and flag=0. If sel_en is multi-hot, ignore it and set collision. sel_en=0 means stay in IDLE.
- WAIT_RESP:
  - rd_valid[idx]=1: capture the rd_data slice and go to PUSH.
  - Otherwise the counter increments. When counter==TIMEOUT-1 with no valid: data=0, flag=1, err_timeout pulses that cycle, go to PUSH.
  - If valid and timeout coincide, valid wins (no flag, no pulse).
  - rd_valid of non-selected switches is ignored.
- PUSH: write the assembled frame into the FIFO when it has room, or when a pop occurs the same cycle. Then go to IDLE. If neither, stay in PUSH (hold the frame).
- busy=1 in WAIT_RESP and PUSH. Any nonzero sel_en while busy is dropped and sets collision.
- Latency:
  - Write with sel_en at cycle 0: PUSH at cycle 1, frame_valid at cycle 2.
  - Read with rd_valid at cycle k>=1: PUSH at k+1, frame_valid at k+2.
  - Timeout with sel_en at cycle 0: err_timeout at cycle TIMEOUT, frame_valid at TIMEOUT+2.
  - rd_valid in the same cycle as sel_en is not seen; the response must arrive at cycle >=1.
- FIFO:
  - Registered head. Pop when frame_valid&frame_ready.
  - Simultaneous push and pop keeps the count unchanged, including when full.
  - Pointers wrap modulo FIFO_DEPTH; order is preserved.
  - frame_out holds stable while frame_valid=1 and frame_ready=0.
- Mid-operation reset: everything returns to reset values immediately. Pending and buffered frames are discarded.

Test Plan:
- Read: sel_en=5'b00100, addr=0x3C, op_id=0x11, wr_rd_s=0; rd_valid[2]=1 with data 0xA5 at cycle 3 -> frame_valid at cycle 5, frame_out=0x113CA540.
- Write: sel_en=5'b00001, addr=0x07, op_id=0x22, wr_rd_s=1 -> frame_valid at cycle 2, frame_out=0x22070010. No wait for rd_valid.
- Timeout: read to switch 4 with no rd_valid -> err_timeout pulse at cycle 15, frame_out=0xXXYY0088 (index 4, flag 1), frame_valid at cycle 17.
- Backpressure: frame_ready=0, issue 5 writes spaced 3 cycles apart -> 4 frames buffered and the 5th held in PUSH with busy=1. Subsequent sel_en sets collision. Raising frame_ready drains all 5 frames in issue order.
- Edge cases:
  - sel_en=5'b00110 -> no frame, collision=1.
  - rd_valid[1] while waiting on switch 3 -> ignored.
  - rd_valid[3] and timeout in the same cycle -> flag=0.
- Reset in WAIT_RESP with 2 frames buffered -> frame_valid=0, busy=0, collision=0 immediately. The next read completes normally.
